// File: rtl/pattern_burst_sched_pkg.sv
// Shared types and constants for the pattern burst scheduler.
package pattern_burst_sched_pkg;

    localparam int unsigned LFSR_W            = 16;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hABCD;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP_SEED  = 16'hFFFF;

    // Fibonacci feedback taps (XNOR form, so all-ones is the lock-up state)
    localparam int unsigned LFSR_TAP_A = 12;
    localparam int unsigned LFSR_TAP_B = 3;
    localparam int unsigned LFSR_TAP_C = 1;
    localparam int unsigned LFSR_TAP_D = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_SEND   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // One LFSR step: XNOR feedback shifted in at the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = ~(s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]);
        return {fb, s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/pattern_burst_sched_src.sv
// Pattern source: counter or LFSR, reloaded on start, stepped per transfer.
// data_nxt is the pattern value that will be current after this clock edge,
// so the scheduler can register it straight into its output flop.
module pattern_burst_sched_src
    import pattern_burst_sched_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [LFSR_W-1:0]    seed,
    input  logic                 mode,
    input  logic                 advance,
    output logic [DATA_SIZE-1:0] data_nxt
);

    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [DATA_SIZE-1:0] cnt_q,  cnt_d;
    logic                 mode_q, mode_d;

    // Next pattern state: load wins over advance
    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load) begin
            lfsr_d = (seed == LFSR_LOCKUP_SEED) ? LFSR_DEFAULT_SEED : seed;
            cnt_d  = seed[DATA_SIZE-1:0];
            mode_d = mode;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
            cnt_d  = cnt_q + DATA_SIZE'(1);
        end
        data_nxt = mode_d ? lfsr_d[DATA_SIZE-1:0] : cnt_d;
    end

    // Pattern registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/pattern_burst_sched.sv
// Burst scheduler: warm-up, then fixed-length bursts with idle gaps on a
// valid/ready stream, sourcing data from the pattern generator.
module pattern_burst_sched
    import pattern_burst_sched_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 4,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned GAP_W     = 8,
    parameter int unsigned WARMUP    = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 cfg_mode,
    input  logic [15:0]          cfg_seed,
    input  logic [LEN_W-1:0]     cfg_burst_len,
    input  logic [GAP_W-1:0]     cfg_gap,
    input  logic [7:0]           cfg_num_bursts,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           burst_cnt
);

    localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    state_e               state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [GAP_W-1:0]     gcnt_q, gcnt_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [7:0]           num_q, num_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 src_load;
    logic                 src_adv;
    logic [DATA_SIZE-1:0] src_nxt;
    logic                 xfer;
    logic [LEN_W-1:0]     len_m1;

    assign xfer   = out_valid_q & out_ready;
    // A zero length behaves as a single-beat burst
    assign len_m1 = (len_q == '0) ? '0 : len_q - LEN_W'(1);

    pattern_burst_sched_src #(
        .DATA_SIZE (DATA_SIZE)
    ) u_src (
        .clk      (clk),
        .rstn     (rstn),
        .load     (src_load),
        .seed     (cfg_seed),
        .mode     (cfg_mode),
        .advance  (src_adv),
        .data_nxt (src_nxt)
    );

    // Next-state, counters and registered-output values
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        gcnt_d      = gcnt_q;
        beat_d      = beat_q;
        burst_cnt_d = burst_cnt_q;
        stop_pend_d = stop_pend_q;
        len_d       = len_q;
        gap_d       = gap_q;
        num_d       = num_q;
        src_load    = 1'b0;
        src_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    state_d     = ST_WARMUP;
                    wcnt_d      = '0;
                    beat_d      = '0;
                    burst_cnt_d = '0;
                    stop_pend_d = 1'b0;
                    len_d       = cfg_burst_len;
                    gap_d       = cfg_gap;
                    num_d       = cfg_num_bursts;
                    src_load    = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (cfg_stop) begin
                    state_d = ST_DONE;
                end else if (wcnt_q == WCNT_W'(WARMUP - 1)) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_SEND: begin
                stop_pend_d = stop_pend_q | cfg_stop;
                if (xfer) begin
                    src_adv = 1'b1;
                    if (out_last_q) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        beat_d      = '0;
                        if ((num_q != 8'd0) && (burst_cnt_d == num_q)) begin
                            state_d = ST_DONE;
                        end else if (stop_pend_d) begin
                            state_d = ST_DONE;
                        end else if (gap_q != '0) begin
                            state_d = ST_GAP;
                            gcnt_d  = '0;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cfg_stop) begin
                    state_d = ST_DONE;
                end else if (gcnt_q == gap_q - GAP_W'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_SEND);
        out_last_d  = out_valid_d && (beat_d == len_m1);
        out_data_d  = out_valid_d ? src_nxt : '0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            beat_q      <= '0;
            burst_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            len_q       <= '0;
            gap_q       <= '0;
            num_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            beat_q      <= beat_d;
            burst_cnt_q <= burst_cnt_d;
            stop_pend_q <= stop_pend_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            num_q       <= num_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_pattern_burst_sched.sv
// Directed bench for pattern_burst_sched with a beat scoreboard.
module tb_pattern_burst_sched;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [15:0]   cfg_seed = '0;
    logic [7:0]    cfg_burst_len = '0;
    logic [7:0]    cfg_gap = '0;
    logic [7:0]    cfg_num_bursts = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [7:0]    burst_cnt;

    int checks = 0;
    int passed = 0;
    int beats_seen = 0;

    // expected beats: {last, data}
    logic [DW:0] exp_q[$];

    pattern_burst_sched #(
        .DATA_SIZE (DW),
        .LEN_W     (8),
        .GAP_W     (8),
        .WARMUP    (24)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_mode       (cfg_mode),
        .cfg_seed       (cfg_seed),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_gap        (cfg_gap),
        .cfg_num_bursts (cfg_num_bursts),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .burst_cnt      (burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        return {~(s[12] ^ s[3] ^ s[1] ^ s[0]), s[15:1]};
    endfunction

    // Push the expected beats of a whole run into the scoreboard
    task automatic push_run(input logic mode, input logic [15:0] seed,
                            input int len, input int nb);
        logic [15:0]   l;
        logic [DW-1:0] c;
        int            n;
        l = (seed == 16'hFFFF) ? 16'hABCD : seed;
        c = seed[DW-1:0];
        n = (len == 0) ? 1 : len;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({(i == n - 1), mode ? l[DW-1:0] : c});
                l = model_lfsr(l);
                c = c + DW'(1);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive config and a one-cycle start; returns one step after the start edge
    task automatic start_run(input logic mode, input logic [15:0] seed,
                             input logic [7:0] len, input logic [7:0] gap,
                             input logic [7:0] nb);
        cfg_mode       = mode;
        cfg_seed       = seed;
        cfg_burst_len  = len;
        cfg_gap        = gap;
        cfg_num_bursts = nb;
        cfg_start      = 1'b1;
        tick(1);
        cfg_start      = 1'b0;
        cfg_seed       = 16'h0000;
        cfg_burst_len  = 8'd7;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!out_valid && k < 200) begin
            tick(1);
            k++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick(1);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic finish_run(input string tag, input logic [7:0] exp_bursts);
        tick(1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_burst_cnt"}, burst_cnt, exp_bursts);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Scoreboard and stability monitor, sampled on the falling edge
    logic        held = 1'b0;
    logic [DW:0] held_v = '0;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (held) check("hold_stable", {out_last, out_data}, held_v);
            if (out_ready) begin
                beats_seen++;
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    check("extra_beat", {out_last, out_data}, 32'hFFFF);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e[DW-1:0]);
                    check("beat_last", out_last, e[DW]);
                end
            end else begin
                held   = 1'b1;
                held_v = {out_last, out_data};
            end
        end else begin
            held = 1'b0;
        end
        if (done) check("done_width", prev_done, 0);
        prev_done = done;
    end

    initial begin
        int k;
        int b0;
        int idle;
        int rseq[6] = '{1, 0, 0, 1, 0, 1};

        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_burst_cnt", burst_cnt, 0);
        rstn = 1'b1;
        tick(2);

        // Basic LFSR run
        exp_q.push_back({1'b0, 4'hD});
        exp_q.push_back({1'b0, 4'h6});
        exp_q.push_back({1'b1, 4'h3});
        start_run(1'b1, 16'hABCD, 8'd3, 8'd0, 8'd1);
        check("start_busy", busy, 1);
        wait_valid(k);
        check("first_valid_latency", k, 25);
        wait_done(50);
        finish_run("basic", 8'd1);

        // Counter mode with a 2-cycle gap
        push_run(1'b0, 16'h0005, 4, 2);
        start_run(1'b0, 16'h0005, 8'd4, 8'd2, 8'd2);
        wait_valid(k);
        k = 0;
        while (!(out_valid && out_last) && k < 50) begin
            tick(1);
            k++;
        end
        tick(1);
        idle = 0;
        while (!out_valid && idle < 10) begin
            idle++;
            tick(1);
        end
        check("gap_idle_cycles", idle, 2);
        wait_done(50);
        finish_run("gap", 8'd2);

        // Backpressure
        exp_q.push_back({1'b0, 4'hD});
        exp_q.push_back({1'b0, 4'h6});
        exp_q.push_back({1'b1, 4'h3});
        out_ready = 1'b0;
        start_run(1'b1, 16'hABCD, 8'd3, 8'd0, 8'd1);
        wait_valid(k);
        for (int i = 0; i < 6; i++) begin
            out_ready = rseq[i][0];
            tick(1);
        end
        out_ready = 1'b1;
        wait_done(20);
        finish_run("bp", 8'd1);

        // Stop during warm-up
        b0 = beats_seen;
        start_run(1'b0, 16'h0001, 8'd4, 8'd0, 8'd0);
        tick(5);
        cfg_stop = 1'b1;
        tick(1);
        cfg_stop = 1'b0;
        check("warm_stop_done", done, 1);
        finish_run("warm_stop", 8'd0);
        check("warm_stop_beats", beats_seen - b0, 0);

        // Stop mid-burst on an endless run
        push_run(1'b0, 16'h0000, 4, 1);
        b0 = beats_seen;
        start_run(1'b0, 16'h0000, 8'd4, 8'd0, 8'd0);
        wait_valid(k);
        tick(1);
        cfg_stop = 1'b1;
        tick(1);
        cfg_stop = 1'b0;
        wait_done(30);
        finish_run("mid_stop", 8'd1);
        check("mid_stop_beats", beats_seen - b0, 4);

        // Lock-up seed replaced by default seed
        exp_q.push_back({1'b0, 4'hD});
        exp_q.push_back({1'b0, 4'h6});
        exp_q.push_back({1'b1, 4'h3});
        start_run(1'b1, 16'hFFFF, 8'd3, 8'd0, 8'd1);
        wait_done(60);
        finish_run("lockup_seed", 8'd1);

        // Zero length gives single-beat bursts; counter wraps
        push_run(1'b0, 16'h000E, 0, 3);
        start_run(1'b0, 16'h000E, 8'd0, 8'd0, 8'd3);
        wait_done(60);
        finish_run("len0", 8'd3);

        // Start and stop together are ignored
        cfg_stop = 1'b1;
        start_run(1'b1, 16'h1234, 8'd2, 8'd0, 8'd1);
        cfg_stop = 1'b0;
        check("start_stop_busy", busy, 0);
        tick(3);
        check("start_stop_busy_later", busy, 0);

        // Reset in the middle of a burst, then rerun from the seed
        exp_q.push_back({1'b0, 4'hD});
        exp_q.push_back({1'b0, 4'h6});
        exp_q.push_back({1'b1, 4'h3});
        start_run(1'b1, 16'hABCD, 8'd3, 8'd0, 8'd1);
        wait_valid(k);
        tick(1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        exp_q.delete();
        tick(3);
        rstn = 1'b1;
        tick(1);
        check("post_rst_done", done, 0);
        exp_q.push_back({1'b0, 4'hD});
        exp_q.push_back({1'b0, 4'h6});
        exp_q.push_back({1'b1, 4'h3});
        start_run(1'b1, 16'hABCD, 8'd3, 8'd0, 8'd1);
        wait_done(60);
        finish_run("rerun", 8'd1);

        tick(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
